// File: rtl/cell_fetch_pkg.sv
// Frame geometry shared by the cell controller, cell buffer and cell fetch
// blocks, plus the payload types carried through the fetch output queue.
package cell_fetch_pkg;

   localparam int unsigned FRAME_ROW_CNUM = 30;
   localparam int unsigned FRAME_COL_CNUM = 40;
   localparam int unsigned CELL_NUM       = FRAME_ROW_CNUM * FRAME_COL_CNUM;
   localparam int unsigned CELL_WIDTH     = 768;

   localparam int unsigned CELL_ADDR_W = $clog2(CELL_NUM);
   localparam int unsigned ROW_ADDR_W  = $clog2(FRAME_ROW_CNUM);
   localparam int unsigned COL_ADDR_W  = $clog2(FRAME_COL_CNUM);

   // Position tag captured when a read is issued
   typedef struct packed {
      logic                  last;
      logic [ROW_ADDR_W-1:0] row;
      logic [COL_ADDR_W-1:0] col;
   } cell_tag_t;

   // One output queue entry: tag plus the returned cache word
   typedef struct packed {
      cell_tag_t             tag;
      logic [CELL_WIDTH-1:0] data;
   } cell_entry_t;

endpackage

// File: rtl/cell_fetch_fifo.sv
// 2-entry synchronous FIFO of tagged cells. The head entry is held in its own
// register so the output comes straight from a flop.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write an entry (ignored when full without a pop)
//   pop        : remove the head entry (ignored when empty)
//   dout       : head entry
//   count      : occupancy 0..2; full / empty derived from it
module cell_fetch_fifo
   import cell_fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  logic        pop,
   input  cell_entry_t din,
   output cell_entry_t dout,
   output logic [1:0]  count,
   output logic        full,
   output logic        empty
);

   cell_entry_t head;
   cell_entry_t tail;
   logic        do_pop;
   logic        do_push;

   assign do_pop  = pop && (count != 2'd0);
   assign do_push = push && ((count != 2'd2) || do_pop);

   // Shift-style storage: head is always entry 0, tail is entry 1
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head  <= '0;
         tail  <= '0;
         count <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (count == 2'd0) head <= din;
               else               tail <= din;
               count <= count + 2'd1;
            end
            2'b01: begin
               head  <= tail;
               count <= count - 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  head <= din;
               end else begin
                  head <= tail;
                  tail <= din;
               end
            end
            default: ;
         endcase
      end
   end

   assign dout  = head;
   assign full  = (count == 2'd2);
   assign empty = (count == 2'd0);

endmodule

// File: rtl/cell_fetch.sv
// Cell cache reader: on a frame-complete pulse, walks the cache in raster
// order and streams each cell with row/column tags over valid/ready.
//   cell_fetch_start_i : frame written to cache (1-cycle pulse)
//   cell_rd_en_o/addr  : cache read port; data returns one cycle later
//   cell_valid/ready   : downstream handshake for data/row/col/last
//   fetch_busy_o       : block not idle
//   frame_done_o       : pulse on the handshake of the last cell
//   frame_overrun_o    : pulse when a start is dropped
module cell_fetch
   import cell_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cell_fetch_start_i,
   output logic                   cell_rd_en_o,
   output logic [CELL_ADDR_W-1:0] cell_rd_addr_o,
   input  logic [CELL_WIDTH-1:0]  cell_rd_data_i,
   output logic                   cell_valid_o,
   input  logic                   cell_ready_i,
   output logic [CELL_WIDTH-1:0]  cell_data_o,
   output logic [ROW_ADDR_W-1:0]  cell_row_o,
   output logic [COL_ADDR_W-1:0]  cell_col_o,
   output logic                   cell_last_o,
   output logic                   fetch_busy_o,
   output logic                   frame_done_o,
   output logic                   frame_overrun_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]             state;
   logic [1:0]             state_nxt;
   logic [CELL_ADDR_W-1:0] rd_addr;
   logic [ROW_ADDR_W-1:0]  row;
   logic [COL_ADDR_W-1:0]  col;
   cell_tag_t              tag;
   logic                   inflight;
   logic                   pending;
   logic                   pop;
   logic                   rd_en_c;
   logic                   frame_start_c;
   logic [2:0]             occ_c;
   logic [1:0]             fifo_count;
   logic                   fifo_full;
   logic                   fifo_empty;
   cell_entry_t            fifo_din;
   cell_entry_t            fifo_dout;

   assign pop   = cell_valid_o && cell_ready_i;
   // Queue entries plus the read whose data arrives this cycle
   assign occ_c = 3'(fifo_count) + 3'(inflight);

   // Next state and read issue
   always_comb begin
      state_nxt     = state;
      rd_en_c       = 1'b0;
      frame_start_c = 1'b0;
      case (state)
         IDLE: begin
            if (cell_fetch_start_i || pending) begin
               state_nxt     = FETCH;
               frame_start_c = 1'b1;
            end
         end
         FETCH: begin
            rd_en_c = (occ_c < (3'd2 + 3'(pop)));
            if (rd_en_c && (rd_addr == CELL_ADDR_W'(CELL_NUM - 1)))
               state_nxt = DRAIN;
         end
         DRAIN: begin
            // Leave as the final queued cell is handed off
            if (!inflight && ((fifo_count - 2'(pop)) == 2'd0))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Address / raster counters and the tag for the read in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_addr  <= '0;
         row      <= '0;
         col      <= '0;
         tag      <= '0;
         inflight <= 1'b0;
      end else begin
         inflight <= rd_en_c;
         if (frame_start_c) begin
            rd_addr <= '0;
            row     <= '0;
            col     <= '0;
         end else if (rd_en_c) begin
            rd_addr  <= rd_addr + CELL_ADDR_W'(1);
            tag.last <= (rd_addr == CELL_ADDR_W'(CELL_NUM - 1));
            tag.row  <= row;
            tag.col  <= col;
            if (col == COL_ADDR_W'(FRAME_COL_CNUM - 1)) begin
               col <= '0;
               row <= row + ROW_ADDR_W'(1);
            end else begin
               col <= col + COL_ADDR_W'(1);
            end
         end
      end
   end

   // One queued start may wait behind the current frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
      end else if (state == IDLE) begin
         pending <= pending && cell_fetch_start_i;
      end else if (cell_fetch_start_i && !pending) begin
         pending <= 1'b1;
      end
   end

   always_comb begin
      fifo_din      = '0;
      fifo_din.tag  = tag;
      fifo_din.data = cell_rd_data_i;
   end

   cell_fetch_fifo u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (inflight),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Credit logic must never return data into a full queue
   assert property (@(posedge clk) disable iff (!rst_n)
                    !(inflight && fifo_full && !pop));

   assign cell_rd_en_o    = rd_en_c;
   assign cell_rd_addr_o  = rd_addr;
   assign cell_valid_o    = !fifo_empty;
   assign cell_data_o     = fifo_dout.data;
   assign cell_row_o      = fifo_dout.tag.row;
   assign cell_col_o      = fifo_dout.tag.col;
   assign cell_last_o     = fifo_dout.tag.last;
   assign fetch_busy_o    = (state != IDLE);
   assign frame_done_o    = pop && fifo_dout.tag.last;
   assign frame_overrun_o = cell_fetch_start_i && (state != IDLE) && pending;

endmodule

// File: tb/tb_cell_fetch.sv
// Self-checking bench for cell_fetch: cache model returning an address-derived
// pattern, expected cell stream computed from raster position and cycle count.
module tb_cell_fetch;
   import cell_fetch_pkg::*;

   localparam int NC   = int'(CELL_NUM);
   localparam int NCOL = int'(FRAME_COL_CNUM);

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   cell_fetch_start_i = 1'b0;
   logic                   cell_ready_i = 1'b1;
   logic [CELL_WIDTH-1:0]  cell_rd_data_i = '0;
   logic                   cell_rd_en_o;
   logic [CELL_ADDR_W-1:0] cell_rd_addr_o;
   logic                   cell_valid_o;
   logic [CELL_WIDTH-1:0]  cell_data_o;
   logic [ROW_ADDR_W-1:0]  cell_row_o;
   logic [COL_ADDR_W-1:0]  cell_col_o;
   logic                   cell_last_o;
   logic                   fetch_busy_o;
   logic                   frame_done_o;
   logic                   frame_overrun_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   cell_fetch dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .cell_fetch_start_i (cell_fetch_start_i),
      .cell_rd_en_o       (cell_rd_en_o),
      .cell_rd_addr_o     (cell_rd_addr_o),
      .cell_rd_data_i     (cell_rd_data_i),
      .cell_valid_o       (cell_valid_o),
      .cell_ready_i       (cell_ready_i),
      .cell_data_o        (cell_data_o),
      .cell_row_o         (cell_row_o),
      .cell_col_o         (cell_col_o),
      .cell_last_o        (cell_last_o),
      .fetch_busy_o       (fetch_busy_o),
      .frame_done_o       (frame_done_o),
      .frame_overrun_o    (frame_overrun_o)
   );

   function automatic logic [CELL_WIDTH-1:0] cell_pattern(input int a);
      logic [CELL_WIDTH-1:0] r;
      for (int i = 0; i < int'(CELL_WIDTH / 32); i++)
         r[i*32 +: 32] = 32'(a) * 32'h9E3779B1 + 32'(i) * 32'h01000193 + 32'h1;
      return r;
   endfunction

   // Cache: word for the address read last cycle, junk otherwise
   always @(posedge clk) begin
      if (cell_rd_en_o) cell_rd_data_i <= cell_pattern(int'(cell_rd_addr_o));
      else              cell_rd_data_i <= {24{$urandom()}};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Start high during cycle 0; returns inside cycle 1
   task automatic pulse_start();
      tick();
      cell_fetch_start_i = 1'b1;
      tick();
      cell_fetch_start_i = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_checks++;
      if ({cell_rd_en_o, cell_rd_addr_o, cell_valid_o, cell_row_o, cell_col_o, cell_last_o,
           fetch_busy_o, frame_done_o, frame_overrun_o} !== '0 || cell_data_o !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: en=%b addr=%0d valid=%b busy=%b, all required 0",
                  cell_rd_en_o, cell_rd_addr_o, cell_valid_o, fetch_busy_o);
      end
      tick(); tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         n_checks++;
         if (cell_rd_en_o !== 1'b0 || cell_valid_o !== 1'b0 || fetch_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: en=%b valid=%b busy=%b, required 0 0 0",
                     cell_rd_en_o, cell_valid_o, fetch_busy_o);
         end
         tick();
      end
   endtask

   task automatic test_full_frame();
      int n;
      logic [ROW_ADDR_W-1:0] r39, r40, rlast;
      logic [COL_ADDR_W-1:0] c39, c40, clast;
      r39 = 'x; r40 = 'x; rlast = 'x; c39 = 'x; c40 = 'x; clast = 'x;
      cell_ready_i = 1'b1;
      pulse_start();
      for (int c = 1; c <= NC + 5; c++) begin
         @(negedge clk);
         n = c - 3;
         n_checks++;
         if (fetch_busy_o !== 1'(c <= NC + 2)) begin
            n_fail++;
            $display("FAIL full_busy cycle %0d: got %b required %b", c, fetch_busy_o, c <= NC + 2);
         end
         if (c == 1) begin
            n_checks++;
            if (cell_rd_en_o !== 1'b1 || cell_rd_addr_o !== '0) begin
               n_fail++;
               $display("FAIL full_first_read: en=%b addr=%0d required 1 0", cell_rd_en_o, cell_rd_addr_o);
            end
         end
         n_checks++;
         if (cell_valid_o !== 1'(n >= 0 && n < NC)) begin
            n_fail++;
            $display("FAIL full_valid cycle %0d: got %b required %b", c, cell_valid_o, n >= 0 && n < NC);
         end else if (cell_valid_o) begin
            n_checks++;
            if (cell_data_o !== cell_pattern(n) || cell_row_o !== ROW_ADDR_W'(n / NCOL) ||
                cell_col_o !== COL_ADDR_W'(n % NCOL) || cell_last_o !== 1'(n == NC - 1) ||
                frame_done_o !== 1'(n == NC - 1)) begin
               n_fail++;
               $display("FAIL full_cell %0d: data[31:0]=%h row=%0d col=%0d last=%b done=%b required %h %0d %0d %b",
                        n, cell_data_o[31:0], cell_row_o, cell_col_o, cell_last_o, frame_done_o,
                        cell_pattern(n) & 768'hFFFF_FFFF, n / NCOL, n % NCOL, n == NC - 1);
            end
            if (n == 39)     begin r39 = cell_row_o;   c39 = cell_col_o;   end
            if (n == 40)     begin r40 = cell_row_o;   c40 = cell_col_o;   end
            if (n == NC - 1) begin rlast = cell_row_o; clast = cell_col_o; end
         end else begin
            n_checks++;
            if (frame_done_o !== 1'b0) begin
               n_fail++;
               $display("FAIL full_done_idle cycle %0d: got %b required 0", c, frame_done_o);
            end
         end
         tick();
      end
      n_checks++;
      if (r39 !== 5'd0 || c39 !== 6'd39 || r40 !== 5'd1 || c40 !== 6'd0) begin
         n_fail++;
         $display("FAIL col_wrap: (%0d,%0d)->(%0d,%0d) required (0,39)->(1,0)", r39, c39, r40, c40);
      end
      n_checks++;
      if (rlast !== 5'd29 || clast !== 6'd39) begin
         n_fail++;
         $display("FAIL last_pos: (%0d,%0d) required (29,39)", rlast, clast);
      end
   endtask

   task automatic test_random_ready();
      int issued, popped, dones;
      logic pop, stall, fin;
      logic [CELL_WIDTH-1:0] h_data;
      logic [ROW_ADDR_W-1:0] h_row;
      logic [COL_ADDR_W-1:0] h_col;
      logic h_last;
      issued = 0; popped = 0; dones = 0; stall = 1'b0; fin = 1'b0;
      h_data = '0; h_row = '0; h_col = '0; h_last = 1'b0;
      cell_ready_i = 1'b1;
      pulse_start();
      for (int c = 1; c <= 8 * NC && !fin; c++) begin
         cell_ready_i = 1'($urandom_range(0, 1));
         @(negedge clk);
         pop = cell_valid_o && cell_ready_i;
         if (cell_rd_en_o) begin
            n_checks++;
            if (issued - popped - int'(pop) >= 2 || int'(cell_rd_addr_o) != issued) begin
               n_fail++;
               $display("FAIL rand_read: addr=%0d outstanding=%0d required addr %0d outstanding<2",
                        cell_rd_addr_o, issued - popped - int'(pop), issued);
            end
            issued++;
         end
         if (stall) begin
            n_checks++;
            if (cell_valid_o !== 1'b1 || cell_data_o !== h_data || cell_row_o !== h_row ||
                cell_col_o !== h_col || cell_last_o !== h_last) begin
               n_fail++;
               $display("FAIL rand_stable cycle %0d: valid=%b row=%0d col=%0d required held 1 %0d %0d",
                        c, cell_valid_o, cell_row_o, cell_col_o, h_row, h_col);
            end
         end
         if (pop) begin
            n_checks++;
            if (popped >= NC || cell_data_o !== cell_pattern(popped) ||
                cell_row_o !== ROW_ADDR_W'(popped / NCOL) || cell_col_o !== COL_ADDR_W'(popped % NCOL) ||
                cell_last_o !== 1'(popped == NC - 1)) begin
               n_fail++;
               $display("FAIL rand_cell %0d: row=%0d col=%0d last=%b required %0d %0d %b",
                        popped, cell_row_o, cell_col_o, cell_last_o,
                        popped / NCOL, popped % NCOL, popped == NC - 1);
            end
         end
         n_checks++;
         if (frame_done_o !== 1'(pop && popped == NC - 1)) begin
            n_fail++;
            $display("FAIL rand_done cycle %0d: got %b required %b", c, frame_done_o, pop && popped == NC - 1);
         end
         if (frame_done_o) dones++;
         if (pop) popped++;
         stall  = cell_valid_o && !cell_ready_i;
         h_data = cell_data_o; h_row = cell_row_o; h_col = cell_col_o; h_last = cell_last_o;
         if (popped == NC && !fetch_busy_o) fin = 1'b1;
         tick();
      end
      cell_ready_i = 1'b1;
      n_checks++;
      if (fin !== 1'b1 || issued != NC || popped != NC || dones != 1) begin
         n_fail++;
         $display("FAIL rand_totals: finished=%b issued=%0d popped=%0d dones=%0d required 1 %0d %0d 1",
                  fin, issued, popped, dones, NC, NC);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      logic exp_busy;
      cell_ready_i = 1'b1;
      pulse_start();
      for (int c = 1; c <= 2 * NC + 8; c++) begin
         cell_fetch_start_i = 1'(c == 500);
         @(negedge clk);
         if (c >= 3 && c <= NC + 2)                 n = c - 3;
         else if (c >= NC + 6 && c <= 2 * NC + 5)   n = c - (NC + 6);
         else                                       n = -1;
         exp_busy = 1'(c <= NC + 2 || (c >= NC + 4 && c <= 2 * NC + 5));
         n_checks++;
         if (fetch_busy_o !== exp_busy || frame_overrun_o !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy cycle %0d: busy=%b overrun=%b required %b 0",
                     c, fetch_busy_o, frame_overrun_o, exp_busy);
         end
         if (c == NC + 4) begin
            n_checks++;
            if (cell_rd_en_o !== 1'b1 || cell_rd_addr_o !== '0) begin
               n_fail++;
               $display("FAIL b2b_second_read: en=%b addr=%0d required 1 0", cell_rd_en_o, cell_rd_addr_o);
            end
         end
         n_checks++;
         if (cell_valid_o !== 1'(n >= 0) ||
             (n >= 0 && (cell_data_o !== cell_pattern(n) || cell_row_o !== ROW_ADDR_W'(n / NCOL) ||
                         cell_col_o !== COL_ADDR_W'(n % NCOL) || frame_done_o !== 1'(n == NC - 1)))) begin
            n_fail++;
            $display("FAIL b2b_cell cycle %0d: valid=%b row=%0d col=%0d done=%b required cell %0d",
                     c, cell_valid_o, cell_row_o, cell_col_o, frame_done_o, n);
         end
         tick();
      end
      cell_fetch_start_i = 1'b0;
   endtask

   task automatic test_overrun();
      int s2, s3, pops, lasts, overruns;
      s2 = int'($urandom_range(10, 600));
      s3 = s2 + int'($urandom_range(1, 400));
      pops = 0; lasts = 0; overruns = 0;
      cell_ready_i = 1'b1;
      pulse_start();
      for (int c = 1; c <= 2 * NC + 10; c++) begin
         cell_fetch_start_i = 1'(c == s2 || c == s3);
         @(negedge clk);
         n_checks++;
         if (frame_overrun_o !== 1'(c == s3)) begin
            n_fail++;
            $display("FAIL ovr_pulse cycle %0d: got %b required %b", c, frame_overrun_o, c == s3);
         end
         if (frame_overrun_o) overruns++;
         if (cell_valid_o && cell_ready_i) pops++;
         if (cell_valid_o && cell_ready_i && cell_last_o) lasts++;
         tick();
      end
      cell_fetch_start_i = 1'b0;
      n_checks++;
      if (pops != 2 * NC || lasts != 2 || overruns != 1 || fetch_busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ovr_totals: pops=%0d lasts=%0d overruns=%0d busy=%b required %0d 2 1 0",
                  pops, lasts, overruns, fetch_busy_o, 2 * NC);
      end
   endtask

   task automatic test_reset_mid();
      cell_ready_i = 1'b1;
      pulse_start();
      for (int c = 1; c <= NC / 2 + 6; c++) begin
         cell_ready_i = 1'(c < NC / 2 + 3);
         @(negedge clk);
         if (c == NC / 2 + 6) begin
            n_checks++;
            if (cell_valid_o !== 1'b1 || cell_row_o !== ROW_ADDR_W'((NC / 2) / NCOL) ||
                cell_col_o !== COL_ADDR_W'((NC / 2) % NCOL) || cell_data_o !== cell_pattern(NC / 2)) begin
               n_fail++;
               $display("FAIL mid_stalled: valid=%b row=%0d col=%0d required 1 %0d %0d",
                        cell_valid_o, cell_row_o, cell_col_o, (NC / 2) / NCOL, (NC / 2) % NCOL);
            end
         end
         tick();
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({cell_rd_en_o, cell_rd_addr_o, cell_valid_o, cell_row_o, cell_col_o, cell_last_o,
           fetch_busy_o, frame_done_o, frame_overrun_o} !== '0 || cell_data_o !== '0) begin
         n_fail++;
         $display("FAIL mid_async_reset: en=%b addr=%0d valid=%b row=%0d busy=%b, all required 0",
                  cell_rd_en_o, cell_rd_addr_o, cell_valid_o, cell_row_o, fetch_busy_o);
      end
      cell_ready_i = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (fetch_busy_o !== 1'b0 || cell_rd_en_o !== 1'b0 || cell_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_idle: busy=%b en=%b valid=%b required 0 0 0", fetch_busy_o, cell_rd_en_o, cell_valid_o);
      end
      pulse_start();
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         if (c == 1) begin
            n_checks++;
            if (cell_rd_en_o !== 1'b1 || cell_rd_addr_o !== '0) begin
               n_fail++;
               $display("FAIL mid_restart_read: en=%b addr=%0d required 1 0", cell_rd_en_o, cell_rd_addr_o);
            end
         end
         if (c == 3) begin
            n_checks++;
            if (cell_valid_o !== 1'b1 || cell_row_o !== '0 || cell_col_o !== '0 || cell_data_o !== cell_pattern(0)) begin
               n_fail++;
               $display("FAIL mid_restart_cell: valid=%b row=%0d col=%0d required 1 0 0",
                        cell_valid_o, cell_row_o, cell_col_o);
            end
         end
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_random_ready();
      test_back_to_back();
      test_overrun();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
